dsp_mac_seq: RTL and testbench
==============================

# dsp_mac_seq

Sequencer that runs multiply-accumulate (dot-product) jobs on one DSP slice. It takes a job length, streams signed A/B operand pairs into the slice, and drives the slice's clock enables and mode words so the first product of each job starts the accumulator and later products add to it. It hands the 48-bit sum back over a valid/ready result port. It sits between a stream source (FIR/correlator front end) and a single DSP slice instance configured with AREG=1, BREG=1, MREG=1, PREG=1 and all mode registers bypassed.

## Interface
- N_W, 10, width of the job-length field; a job is 1..2^N_W terms.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- cfg_valid  in  1  job request.
- cfg_ready  out  1  job accepted when high with cfg_valid.
- cfg_len  in  N_W  number of terms minus 1.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  operand pair accepted when high with in_valid.
- in_a  in  25  signed multiplicand.
- in_b  in  18  signed multiplier.
- dsp_a  out  30  in_a sign-extended to 30 bits, driven to slice A.
- dsp_b  out  18  in_b, driven to slice B.
- dsp_cea2, dsp_ceb2, dsp_cem, dsp_cep  out  1 each  slice clock enables.
- dsp_opmode  out  7  slice OP_MODE.
- dsp_alumode  out  4  slice ALU_MODE, constant 4'b0000 (Z+X+Y+CIN).
- dsp_inmode  out  5  constant 5'b00000 (A2, B2, no pre-adder).
- dsp_carryinsel  out  2  constant 2'b00; slice CARRYIN tied 0 outside this block.
- dsp_p  in  48  slice P output.
- res_valid  out  1  result available.
- res_ready  in  1  result consumed when high with res_valid.
- res_data  out  48  job sum, equal to dsp_p while res_valid.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: cfg_ready=1. On cfg_valid, load cnt<=cfg_len, set first<=1, go to RUN.
- RUN: in_ready=1. An accept (in_valid&&in_ready) asserts dsp_cea2/dsp_ceb2 in the same cycle. It pushes tag {valid=1, first} into a 2-stage tag pipe and clears first. On an accept with cnt==0, go to DRAIN; otherwise cnt decrements.
- Tag pipe: stage1 (A/B reg valid) feeds dsp_cem=stage1.valid. Stage2 (M reg valid) feeds dsp_cep=stage2.valid. A cycle with no accept pushes an invalid tag, so bubbles propagate and no stall logic is needed.
- dsp_opmode = stage2.first ? 7'h05 (X=M, Y=M, Z=0) : 7'h25 (X=M, Y=M, Z=P). It is valid only when dsp_cep=1; otherwise it is held at 7'h25.
- DRAIN: in_ready=0. Go to DONE on the cycle where stage2.valid&&stage2.last, i.e. when the final dsp_cep fires. A last flag travels in the tag alongside first.
- DONE: res_valid=1, res_data=dsp_p. P holds because dsp_cep=0. On res_ready, go to IDLE.
- Arithmetic: each product is 43-bit signed. Accumulation is 48-bit two's complement; it wraps on overflow, with no saturation and no flag.
- cfg_ready is low outside IDLE. A cfg_valid in DONE is not accepted until the following IDLE cycle, giving one bubble per job.
- Reset: state=IDLE, cnt=0, first=0, tag pipe cleared. All CEs are 0, in_ready=0, res_valid=0, busy=0, cfg_ready=1, dsp_opmode=7'h25.
- Reset mid-job discards the job. Slice P contents are don't-care until the next first product.

## Timing
- Last operand accepted in cycle t: dsp_cem=1 in t+1, dsp_cep=1 in t+2, res_valid=1 and the final sum on dsp_p in t+3.
- Minimum job (1 term): cfg accepted in cycle c, operand accepted c+1, result c+4.
- Throughput: one term per cycle while in_valid stays high.
- res_valid stays high, with res_data stable, until res_ready.

## Structure
- Package dsp_ctrl_pkg holds:
  - the state enum;
  - OPMODE_MM_ZERO=7'h05 and OPMODE_MM_P=7'h25;
  - ALUMODE_ADD, INMODE_A2B2 and CARRYINSEL_CIN;
  - the tag struct {valid, first, last}.
- Sub-module dsp_tag_pipe: a parameterised-depth shift register of tags, reused when MREG/PREG settings change.
- Bench wraps dsp_mac_seq with the real slice.

## Test plan
- cfg_len=0, a=3, b=4 -> res_data=12; res_valid 3 cycles after the operand accept.
- cfg_len=3, a=1,2,3,4, b=2 back-to-back -> 20, with dsp_opmode=7'h05 only on the first cep.
- Signed: a=-5,b=7 then a=2,b=3 -> -29 (48'hFFFF_FFFF_FFE3).
- in_valid toggling 1,0,0,1,0,1 over a 3-term job (2,3,4 × 10) -> 90; CEs are low during bubbles.
- Two jobs back-to-back (first result 100, second a single term 5×5) -> second result 25, proving the first term clears the accumulator; res_ready held low 5 cycles keeps res_data stable.
- rst asserted mid-RUN after 2 of 5 terms -> next cycle IDLE, all outputs at reset values; a new 1-term job 6×7 -> 42.

Source files
------------

// File: rtl/dsp_ctrl_pkg.sv
// Shared types and constants for the DSP-slice MAC sequencer.
package dsp_ctrl_pkg;

  localparam int A_W     = 25;
  localparam int B_W     = 18;
  localparam int DSP_A_W = 30;
  localparam int P_W     = 48;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // X=M, Y=M, Z=0: first product of a job starts a fresh sum
  localparam logic [6:0] OPMODE_MM_ZERO = 7'h05;
  // X=M, Y=M, Z=P: later products add onto the running sum
  localparam logic [6:0] OPMODE_MM_P    = 7'h25;

  localparam logic [3:0] ALUMODE_ADD    = 4'b0000;
  localparam logic [4:0] INMODE_A2B2    = 5'b00000;
  localparam logic [1:0] CARRYINSEL_CIN = 2'b00;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tag_t;

  localparam tag_t TAG_NONE = '{valid: 1'b0, first: 1'b0, last: 1'b0};

  // Slice A port is 30 bits wide; the multiplier only uses the low 25.
  function automatic logic [DSP_A_W-1:0] sext_a(input logic [A_W-1:0] a);
    return {{(DSP_A_W - A_W){a[A_W-1]}}, a};
  endfunction

  // Mode word for the P stage; idle cycles hold the accumulate encoding.
  function automatic logic [6:0] opmode_for(input logic valid, input logic first);
    logic [6:0] op;
    if (valid && first) begin
      op = OPMODE_MM_ZERO;
    end else begin
      op = OPMODE_MM_P;
    end
    return op;
  endfunction

endpackage

// File: rtl/dsp_tag_pipe.sv
// Shift register of tags that mirrors the slice's internal register stages.
// Stage 0 lines up with the A/B registers, the last stage with the M register.
module dsp_tag_pipe
  import dsp_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  tag_t             push,
  output logic [DEPTH-1:0] valid_vec,
  output logic             tail_first,
  output logic             tail_last
);

  tag_t [DEPTH-1:0] pipe;

  // Shift a new tag in every cycle; empty cycles carry an invalid tag as a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe <= '0;
    end else begin
      pipe[0] <= push;
      for (int i = 1; i < DEPTH; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  // Fan out per-stage valids and the tail's job markers
  always_comb begin
    valid_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i] = pipe[i].valid;
    end
    tail_first = pipe[DEPTH-1].first;
    tail_last  = pipe[DEPTH-1].last;
  end

endmodule

// File: rtl/dsp_mac_seq.sv
// Dot-product job sequencer for a single DSP slice (AREG=BREG=MREG=PREG=1).
// Streams operand pairs into the slice, steers the Z mux so each job's first
// product restarts the accumulator, and returns the 48-bit wrapped sum.
module dsp_mac_seq
  import dsp_ctrl_pkg::*;
#(
  parameter int N_W = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [N_W-1:0] cfg_len,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [24:0]    in_a,
  input  logic [17:0]    in_b,
  output logic [29:0]    dsp_a,
  output logic [17:0]    dsp_b,
  output logic           dsp_cea2,
  output logic           dsp_ceb2,
  output logic           dsp_cem,
  output logic           dsp_cep,
  output logic [6:0]     dsp_opmode,
  output logic [3:0]     dsp_alumode,
  output logic [4:0]     dsp_inmode,
  output logic [1:0]     dsp_carryinsel,
  input  logic [47:0]    dsp_p,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [47:0]    res_data,
  output logic           busy
);

  state_t         state;
  logic [N_W-1:0] cnt;
  logic           first;

  logic           accept;
  tag_t           push;
  logic [1:0]     stage_valid;
  logic           tail_first;
  logic           tail_last;

  // An operand pair is taken whenever RUN is active and the source offers one
  always_comb begin
    accept = in_valid && (state == ST_RUN);
  end

  // Build the tag for this cycle; no accept means a bubble enters the pipe
  always_comb begin
    push = TAG_NONE;
    if (accept) begin
      push.valid = 1'b1;
      push.first = first;
      push.last  = (cnt == {N_W{1'b0}});
    end else begin
      push = TAG_NONE;
    end
  end

  dsp_tag_pipe #(
    .DEPTH (2)
  ) u_tag_pipe (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .valid_vec  (stage_valid),
    .tail_first (tail_first),
    .tail_last  (tail_last)
  );

  // Job control: load length, count accepts, wait for the final P update, hand off
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= {N_W{1'b0}};
      first <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cfg_valid) begin
            cnt   <= cfg_len;
            first <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (in_valid) begin
            first <= 1'b0;
            if (cnt == {N_W{1'b0}}) begin
              state <= ST_DRAIN;
            end else begin
              cnt <= cnt - N_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          // Leave as the last product is folded into P; P is final next cycle
          if (stage_valid[1] && tail_last) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Handshake and status decode straight from the state register
  always_comb begin
    cfg_ready = (state == ST_IDLE);
    in_ready  = (state == ST_RUN);
    res_valid = (state == ST_DONE);
    busy      = (state != ST_IDLE);
  end

  // Slice operand and clock-enable drive; CEs follow the tags through the slice
  always_comb begin
    dsp_a          = sext_a(in_a);
    dsp_b          = in_b;
    dsp_cea2       = accept;
    dsp_ceb2       = accept;
    dsp_cem        = stage_valid[0];
    dsp_cep        = stage_valid[1];
    dsp_opmode     = opmode_for(stage_valid[1], tail_first);
    dsp_alumode    = ALUMODE_ADD;
    dsp_inmode     = INMODE_A2B2;
    dsp_carryinsel = CARRYINSEL_CIN;
  end

  // P is held (CEP low) in DONE, so the slice output is the result directly
  always_comb begin
    res_data = dsp_p;
  end

endmodule

// File: tb/tb_dsp_mac_seq.sv
// Directed bench: dsp_mac_seq driving a behavioural DSP slice (A2/B2/M/P regs).
module tb_dsp_mac_seq;

  localparam int N_W = 10;

  logic           clk = 1'b0;
  logic           rst;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [N_W-1:0] cfg_len;
  logic           in_valid;
  logic           in_ready;
  logic [24:0]    in_a;
  logic [17:0]    in_b;
  logic [29:0]    dsp_a;
  logic [17:0]    dsp_b;
  logic           dsp_cea2, dsp_ceb2, dsp_cem, dsp_cep;
  logic [6:0]     dsp_opmode;
  logic [3:0]     dsp_alumode;
  logic [4:0]     dsp_inmode;
  logic [1:0]     dsp_carryinsel;
  logic [47:0]    dsp_p;
  logic           res_valid;
  logic           res_ready;
  logic [47:0]    res_data;
  logic           busy;

  int checks   = 0;
  int failures = 0;
  int n_first  = 0;

  always #5 clk = ~clk;

  dsp_mac_seq #(.N_W(N_W)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .dsp_a(dsp_a), .dsp_b(dsp_b),
    .dsp_cea2(dsp_cea2), .dsp_ceb2(dsp_ceb2), .dsp_cem(dsp_cem), .dsp_cep(dsp_cep),
    .dsp_opmode(dsp_opmode), .dsp_alumode(dsp_alumode), .dsp_inmode(dsp_inmode),
    .dsp_carryinsel(dsp_carryinsel), .dsp_p(dsp_p),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy)
  );

  // Behavioural slice: A2/B2 -> M -> P, Z mux chosen by OPMODE[6:4]
  logic [29:0]        a2 = '0;
  logic signed [17:0] b2 = '0;
  logic signed [47:0] m  = '0;
  logic [47:0]        p  = '0;
  logic [47:0]        zmux, xymux;

  always_comb begin
    case (dsp_opmode[6:4])
      3'b010:  zmux = p;
      default: zmux = 48'd0;
    endcase
    xymux = (dsp_opmode[3:0] == 4'b0101) ? m : 48'd0;
  end

  always @(posedge clk) begin
    if (dsp_cea2) a2 <= dsp_a;
    if (dsp_ceb2) b2 <= dsp_b;
    if (dsp_cem)  m  <= $signed(a2[24:0]) * b2;
    if (dsp_cep)  p  <= zmux + xymux;
  end
  assign dsp_p = p;

  // Count P updates that restart the accumulator
  always @(negedge clk) begin
    if (dsp_cep && dsp_opmode == 7'h05) n_first <= n_first + 1;
  end

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [N_W-1:0] len);
    cfg_valid = 1'b1;
    cfg_len   = len;
    #1;
    chk("cfg_ready", {47'd0, cfg_ready}, 48'd1);
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic feed(input logic [24:0] a, input logic [17:0] b);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    #1;
    chk("in_accept", {46'd0, in_ready, dsp_cea2}, 48'd3);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_res(input string tag);
    int n = 0;
    while (!res_valid && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_res_valid"}, {47'd0, res_valid}, 48'd1);
  endtask

  task automatic consume(input string tag, input logic [47:0] exp);
    chk({tag, "_data"}, res_data, exp);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk({tag, "_idle"}, {46'd0, busy, cfg_ready}, 48'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    logic [5:0]  pat;
    logic [24:0] seq_a [3];
    rst = 1'b1; cfg_valid = 1'b0; cfg_len = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; res_ready = 1'b0;
    step(); step();

    // Reset values
    chk("rst_status", {44'd0, cfg_ready, in_ready, res_valid, busy}, 48'h8);
    chk("rst_ce", {44'd0, dsp_cea2, dsp_ceb2, dsp_cem, dsp_cep}, 48'h0);
    chk("rst_opmode", {41'd0, dsp_opmode}, 48'h25);
    chk("const_modes", {37'd0, dsp_alumode, dsp_inmode, dsp_carryinsel}, 48'h0);
    rst = 1'b0;
    step();

    // 1-term job, latency from last accept
    do_cfg(10'd0);
    feed(25'd3, 18'd4);
    chk("t1_cem", {46'd0, dsp_cem, dsp_cep}, 48'h2);
    chk("t1_in_ready", {47'd0, in_ready}, 48'd0);
    step();
    chk("t1_cep", {41'd0, dsp_cep, dsp_opmode[5:0]}, {41'd0, 7'h45});
    chk("t1_res_early", {47'd0, res_valid}, 48'd0);
    step();
    chk("t1_res_valid", {46'd0, res_valid, busy}, 48'h3);
    consume("t1", 48'd12);

    // 4 back-to-back terms, restart mode only on first P update
    f0 = n_first;
    do_cfg(10'd3);
    for (int i = 1; i <= 4; i++) feed(25'(i), 18'd2);
    wait_res("t2");
    consume("t2", 48'd20);
    chk("t2_first_cnt", 48'(n_first - f0), 48'd1);

    // Signed operands
    do_cfg(10'd1);
    feed(-25'sd5, 18'sd7);
    feed(25'sd2, 18'sd3);
    wait_res("t3");
    consume("t3", 48'hFFFF_FFFF_FFE3);

    // Valid toggling 1,0,0,1,0,1 with bubbles
    seq_a[0] = 25'd2; seq_a[1] = 25'd3; seq_a[2] = 25'd4;
    pat = 6'b101001;
    do_cfg(10'd2);
    begin
      int k = 0;
      for (int i = 0; i < 6; i++) begin
        in_valid = pat[i];
        in_a     = pat[i] ? seq_a[k] : 25'd99;
        in_b     = 18'd10;
        #1;
        chk("t4_ce", {46'd0, dsp_cea2, dsp_ceb2}, pat[i] ? 48'h3 : 48'h0);
        if (pat[i]) k++;
        step();
      end
    end
    in_valid = 1'b0;
    wait_res("t4");
    consume("t4", 48'd90);

    // Held result, cfg blocked in DONE, then back-to-back 1-term job
    do_cfg(10'd1);
    feed(25'd6, 18'd10);
    feed(25'd4, 18'd10);
    wait_res("t5a");
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        cfg_valid = 1'b1;
        cfg_len   = 10'd0;
      end
      #1;
      chk("t5_hold", res_data, 48'd100);
      chk("t5_hold_valid", {46'd0, res_valid, cfg_ready}, 48'h2);
      step();
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("t5_cfg_next", {47'd0, cfg_ready}, 48'd1);
    step();
    cfg_valid = 1'b0;
    feed(25'd5, 18'd5);
    wait_res("t5b");
    consume("t5b", 48'd25);

    // Reset mid-RUN then a fresh job
    do_cfg(10'd4);
    feed(25'd1, 18'd1);
    feed(25'd2, 18'd2);
    rst = 1'b1;
    #1;
    chk("t6_status", {44'd0, cfg_ready, in_ready, res_valid, busy}, 48'h8);
    chk("t6_ce", {44'd0, dsp_cea2, dsp_ceb2, dsp_cem, dsp_cep}, 48'h0);
    chk("t6_opmode", {41'd0, dsp_opmode}, 48'h25);
    step();
    rst = 1'b0;
    step();
    do_cfg(10'd0);
    feed(25'd6, 18'd7);
    wait_res("t6");
    consume("t6", 48'd42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
